// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Two-requester register-file writeback arbiter with 2-entry
//            request FIFOs. Define WB_RR_ARB_EN for round-robin arbitration;
//            otherwise requester 0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
  parameter int registerSize  = 8,
  parameter int vectorSize    = 4,
  parameter int selectionBits = 2
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [1:0]                                      reqValid,
  output logic [1:0]                                      reqReady,
  input  logic [1:0]                                      reqScalar,
  input  logic [1:0][selectionBits:0]                     reqReg,
  input  logic [1:0][vectorSize-1:0][registerSize-1:0]    reqData,
  output logic                                            regWrEnSc,
  output logic                                            regWrEnVec,
  output logic [selectionBits:0]                          regToWrite,
  output logic [vectorSize-1:0][registerSize-1:0]         dataOut,
  output logic [1:0]                                      grant,
  output logic                                            busy
);

  localparam int REG_W   = selectionBits + 1;
  localparam int DATA_W  = vectorSize * registerSize;
  localparam int ENTRY_W = 1 + REG_W + DATA_W;

  logic [1:0]         w_push;
  logic [1:0]         w_head_valid;
  logic [1:0]         w_grant;
  logic [1:0]         w_cnt  [2];
  logic [ENTRY_W-1:0] w_head [2];
  logic [ENTRY_W-1:0] w_sel;

  logic               r_wr_en_sc;
  logic               r_wr_en_vec;
  logic [1:0]         r_grant;
  logic [REG_W-1:0]   r_reg;
  logic [DATA_W-1:0]  r_data;

  generate
    for (genvar i = 0; i < 2; i++) begin : g_fifo
      logic [ENTRY_W-1:0] r_mem [2];
      logic               r_wr_ptr;
      logic               r_rd_ptr;
      logic [1:0]         r_cnt;

      // Readiness comes from the registered count only, so a full FIFO
      // refuses a push even in a cycle where it is also being popped.
      assign reqReady[i]     = (r_cnt < 2'd2);
      assign w_push[i]       = reqValid[i] & reqReady[i];
      assign w_head_valid[i] = (r_cnt != 2'd0);
      assign w_cnt[i]        = r_cnt;
      assign w_head[i]       = r_mem[r_rd_ptr];

      always_ff @(posedge clk) begin
        if (w_push[i]) begin
          r_mem[r_wr_ptr] <= {reqScalar[i], reqReg[i], reqData[i]};
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_wr_ptr <= 1'b0;
          r_rd_ptr <= 1'b0;
          r_cnt    <= 2'd0;
        end else begin
          if (w_push[i]) r_wr_ptr <= ~r_wr_ptr;
          if (w_grant[i]) r_rd_ptr <= ~r_rd_ptr;
          case ({w_push[i], w_grant[i]})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
          endcase
        end
      end
    end
  endgenerate

`ifdef WB_RR_ARB_EN
  // r_favour names the requester that wins a tie; it flips to the other
  // requester after every grant.
  logic r_favour;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_favour <= 1'b0;
    end else if (w_grant != 2'b00) begin
      r_favour <= w_grant[0];
    end
  end

  always_comb begin
    w_grant = 2'b00;
    if (w_head_valid == 2'b11) begin
      w_grant = r_favour ? 2'b10 : 2'b01;
    end else begin
      w_grant = w_head_valid;
    end
  end
`else
  always_comb begin
    w_grant = 2'b00;
    if (w_head_valid[0]) begin
      w_grant = 2'b01;
    end else if (w_head_valid[1]) begin
      w_grant = 2'b10;
    end
  end
`endif

  assign w_sel = w_grant[1] ? w_head[1] : w_head[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_en_sc  <= 1'b0;
      r_wr_en_vec <= 1'b0;
      r_grant     <= 2'b00;
      r_reg       <= '0;
      r_data      <= '0;
    end else if (w_grant != 2'b00) begin
      r_wr_en_sc  <= w_sel[ENTRY_W-1];
      r_wr_en_vec <= ~w_sel[ENTRY_W-1];
      r_grant     <= w_grant;
      r_reg       <= w_sel[DATA_W +: REG_W];
      r_data      <= w_sel[DATA_W-1:0];
    end else begin
      r_wr_en_sc  <= 1'b0;
      r_wr_en_vec <= 1'b0;
      r_grant     <= 2'b00;
    end
  end

  assign regWrEnSc  = r_wr_en_sc;
  assign regWrEnVec = r_wr_en_vec;
  assign grant      = r_grant;
  assign regToWrite = r_reg;
  assign dataOut    = r_data;
  assign busy       = (w_cnt[0] != 2'd0) | (w_cnt[1] != 2'd0) | r_wr_en_sc | r_wr_en_vec;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios plus random traffic
// checked against a queue-based reference model.
`default_nettype none

module tb_regfile_wb_arbiter;

`ifdef WB_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic        sc;
    logic [2:0]  rg;
    logic [31:0] d;
  } entry_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [1:0]       reqValid = '0;
  logic [1:0]       reqReady;
  logic [1:0]       reqScalar = '0;
  logic [1:0][2:0]  reqReg = '0;
  logic [1:0][3:0][7:0] reqData = '0;
  logic             regWrEnSc;
  logic             regWrEnVec;
  logic [2:0]       regToWrite;
  logic [3:0][7:0]  dataOut;
  logic [1:0]       grant;
  logic             busy;

  int checks = 0;
  int errors = 0;

  // reference model state
  entry_t     q0[$];
  entry_t     q1[$];
  logic       m_fav = 1'b0;
  logic       m_sc = 1'b0;
  logic       m_vec = 1'b0;
  logic [1:0] m_grant = 2'b00;
  logic [2:0] m_reg = '0;
  logic [31:0] m_data = '0;

  logic [1:0] gs [8];

  regfile_wb_arbiter #(
    .registerSize (8),
    .vectorSize   (4),
    .selectionBits(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .reqValid  (reqValid),
    .reqReady  (reqReady),
    .reqScalar (reqScalar),
    .reqReg    (reqReg),
    .reqData   (reqData),
    .regWrEnSc (regWrEnSc),
    .regWrEnVec(regWrEnVec),
    .regToWrite(regToWrite),
    .dataOut   (dataOut),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, compare after the edge.
  task automatic cyc(input logic [1:0] v, input logic [1:0] sc,
                     input logic [2:0] rg0, input logic [2:0] rg1,
                     input logic [31:0] d0, input logic [31:0] d1);
    entry_t s;
    logic [1:0] g;
    logic acc0, acc1;
    reqValid   = v;
    reqScalar  = sc;
    reqReg[0]  = rg0;
    reqReg[1]  = rg1;
    reqData[0] = d0;
    reqData[1] = d1;
    acc0 = v[0] && (q0.size() < 2);
    acc1 = v[1] && (q1.size() < 2);
    g = 2'b00;
    s = '0;
    if (q0.size() != 0 && q1.size() != 0) g = (RR && m_fav) ? 2'b10 : 2'b01;
    else if (q0.size() != 0) g = 2'b01;
    else if (q1.size() != 0) g = 2'b10;
    if (g == 2'b01) s = q0.pop_front();
    else if (g == 2'b10) s = q1.pop_front();
    m_grant = g;
    if (g != 2'b00) begin
      m_fav  = g[0];
      m_sc   = s.sc;
      m_vec  = !s.sc;
      m_reg  = s.rg;
      m_data = s.d;
    end else begin
      m_sc  = 1'b0;
      m_vec = 1'b0;
    end
    if (acc0) q0.push_back('{sc: sc[0], rg: rg0, d: d0});
    if (acc1) q1.push_back('{sc: sc[1], rg: rg1, d: d1});
    @(posedge clk);
    #1;
    chk("grant",      64'(grant),      64'(m_grant));
    chk("regWrEnSc",  64'(regWrEnSc),  64'(m_sc));
    chk("regWrEnVec", 64'(regWrEnVec), 64'(m_vec));
    chk("regToWrite", 64'(regToWrite), 64'(m_reg));
    chk("dataOut",    64'(dataOut),    64'(m_data));
    chk("reqReady",   64'(reqReady),   64'({q1.size() < 2, q0.size() < 2}));
    chk("busy",       64'(busy),
        64'((q0.size() != 0) || (q1.size() != 0) || m_sc || m_vec));
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(2'b00, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0);
  endtask

  // Asynchronous reset pulse in the middle of a cycle.
  task automatic do_reset();
    reqValid = 2'b00;
    #2;
    reset = 1'b0;
    #1;
    chk("rst_regWrEnSc",  64'(regWrEnSc),  64'd0);
    chk("rst_regWrEnVec", 64'(regWrEnVec), 64'd0);
    chk("rst_grant",      64'(grant),      64'd0);
    chk("rst_regToWrite", 64'(regToWrite), 64'd0);
    chk("rst_dataOut",    64'(dataOut),    64'd0);
    chk("rst_busy",       64'(busy),       64'd0);
    q0.delete();
    q1.delete();
    m_fav = 1'b0; m_sc = 1'b0; m_vec = 1'b0; m_grant = 2'b00;
    m_reg = '0; m_data = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // power-on reset
    @(negedge clk);
    @(negedge clk);
    chk("por_grant",    64'(grant),    64'd0);
    chk("por_dataOut",  64'(dataOut),  64'd0);
    chk("por_busy",     64'(busy),     64'd0);
    reset = 1'b1;
    idle();
    chk("ready_after_release", 64'(reqReady), 64'h3);

    // single scalar push from requester 0
    cyc(2'b01, 2'b01, 3'd3, 3'd0, 32'h0000_00A5, 32'd0);
    chk("single_no_early_write", 64'(grant), 64'd0);
    idle();
    chk("single_grant",   64'(grant),      64'h1);
    chk("single_sc",      64'(regWrEnSc),  64'd1);
    chk("single_reg",     64'(regToWrite), 64'd3);
    chk("single_data0",   64'(dataOut[0]), 64'hA5);
    idle();
    chk("single_one_cycle", 64'(grant), 64'd0);
    chk("single_hold_reg",  64'(regToWrite), 64'd3);

    // three back-to-back vector pushes from requester 1
    cyc(2'b10, 2'b00, 3'd0, 3'd1, 32'd0, 32'h1111_1111);
    cyc(2'b10, 2'b00, 3'd0, 3'd2, 32'd0, 32'h2222_2222);
    chk("b2b_reg1", 64'(regToWrite), 64'd1);
    chk("b2b_vec1", 64'(regWrEnVec), 64'd1);
    cyc(2'b10, 2'b00, 3'd0, 3'd3, 32'd0, 32'h3333_3333);
    chk("b2b_reg2", 64'(regToWrite), 64'd2);
    idle();
    chk("b2b_reg3", 64'(regToWrite), 64'd3);
    chk("b2b_vec3", 64'(regWrEnVec), 64'd1);
    idle();

    // both requesters push every cycle
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cyc(2'b11, 2'b11, 3'(k), 3'(k + 4), $urandom, $urandom);
      gs[k] = grant;
      if (k == 1 && !RR) chk("fixed_ready1_low", 64'(reqReady[1]), 64'd0);
    end
    for (int k = 1; k < 5; k++) begin
      if (RR) chk("rr_alternate", 64'(gs[k]), (k % 2 == 1) ? 64'h1 : 64'h2);
      else    chk("fixed_grant0", 64'(gs[k]), 64'h1);
    end
    for (int k = 0; k < 6; k++) idle();

    // same-register collision: 11 then 22
    do_reset();
    cyc(2'b11, 2'b11, 3'd5, 3'd5, 32'h0000_0011, 32'h0000_0022);
    idle();
    chk("coll_first",  64'(dataOut[0]), 64'h11);
    chk("coll_first_g", 64'(grant), 64'h1);
    idle();
    chk("coll_second", 64'(dataOut[0]), 64'h22);
    chk("coll_second_g", 64'(grant), 64'h2);
    idle();

    // reset while both FIFOs hold entries
    for (int k = 0; k < 4; k++) cyc(2'b11, 2'($urandom), 3'($urandom), 3'($urandom), $urandom, $urandom);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("post_rst_no_write", 64'({regWrEnSc, regWrEnVec}), 64'd0);
    end

    // random traffic
    for (int k = 0; k < 300; k++) begin
      cyc(2'($urandom), 2'($urandom), 3'($urandom), 3'($urandom), $urandom, $urandom);
    end
    for (int k = 0; k < 6; k++) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
